// File: rtl/fir_pkg.sv
// fir_pkg
// Shared definitions for the serial-MAC FIR engine: default geometry constants
// and the controller state encoding.
//   FIR_TAPS       number of taps (power of two, >= 2)
//   FIR_DW         signed sample width
//   FIR_CW         signed coefficient width
//   FIR_AW         accumulator / result width (>= DW+CW)
//   FIR_APPROX_LSB low-bit span handled by the segmented adder (multiple of 4)
package fir_pkg;

   localparam int FIR_TAPS       = 8;
   localparam int FIR_DW         = 16;
   localparam int FIR_CW         = 16;
   localparam int FIR_AW         = 32;
   localparam int FIR_APPROX_LSB = 20;

   // IDLE: waiting for a sample; MAC: one tap per cycle; OUT: result offered.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MAC  = 2'd1,
      OUT  = 2'd2
   } state_t;

endpackage

// File: rtl/eta_acc_adder.sv
// eta_acc_adder
// Combinational AW-bit accumulator adder with an optional error-tolerant mode.
//   a, b       addends (two's complement, result wraps mod 2^AW)
//   approx_en  0: exact sum; 1: segmented low part, exact high part
//   sum        result
// In approximate mode the low APPROX_LSB bits are split into 4-bit segments.
// Each segment resolves its internal carries assuming a zero carry-in; the
// carry it really receives (the zero-carry-in lookahead carry-out of the
// segment below) only flips its lowest sum bit and is not rippled further.
// The upper bits add exactly, fed by the top segment's truncated carry-out.
module eta_acc_adder
   import fir_pkg::*;
#(
   parameter int AW         = FIR_AW,
   parameter int APPROX_LSB = FIR_APPROX_LSB
)(
   input  logic [AW-1:0] a,
   input  logic [AW-1:0] b,
   input  logic          approx_en,
   output logic [AW-1:0] sum
);

   logic [AW-1:0] exact_sum;
   assign exact_sum = a + b;

   generate
      if (APPROX_LSB == 0) begin : g_exact
         assign sum = exact_sum;
      end else begin : g_approx
         localparam int NSEG = APPROX_LSB / 4;
         localparam int HW   = AW - APPROX_LSB;

         // seg_c[j] is the carry delivered into segment j
         logic [NSEG:0]           seg_c;
         logic [APPROX_LSB-1:0]   lo_sum;
         logic [HW-1:0]           hi_sum;

         assign seg_c[0] = 1'b0;

         for (genvar j = 0; j < NSEG; j++) begin : g_seg
            logic [3:0] g;
            logic [3:0] p;
            logic [3:0] c;
            assign g    = a[4*j +: 4] & b[4*j +: 4];
            assign p    = a[4*j +: 4] ^ b[4*j +: 4];
            // bit 0 sees the incoming carry; bits 1..3 use zero-carry-in lookahead
            assign c[0] = seg_c[j];
            assign c[1] = g[0];
            assign c[2] = g[1] | (p[1] & g[0]);
            assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]);
            assign seg_c[j+1] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                              | (p[3] & p[2] & p[1] & g[0]);
            assign lo_sum[4*j +: 4] = p ^ c;
         end

         assign hi_sum = a[AW-1:APPROX_LSB] + b[AW-1:APPROX_LSB] + HW'(seg_c[NSEG]);
         assign sum    = approx_en ? {hi_sum, lo_sum} : exact_sum;
      end
   endgenerate

endmodule

// File: rtl/fir_serial_mac.sv
// fir_serial_mac
// Time-multiplexed FIR engine: one sample in, TAPS multiply-accumulate cycles
// through a single multiplier, one result out.
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready  sample handshake; in_data signed DW-bit sample,
//                        approx_en selects the adder mode for that sample
//   coef_we/addr/data    coefficient write port, honoured only while idle
//   out_valid/out_ready  result handshake; out_data signed AW-bit result
//   busy                 high while computing or holding a result
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is decoded from state only; out_valid and out_data are
// registered and stay stable until out_ready takes them.
// The controller state is held in 'state' for observation.
module fir_serial_mac
   import fir_pkg::*;
#(
   parameter int TAPS       = FIR_TAPS,
   parameter int DW         = FIR_DW,
   parameter int CW         = FIR_CW,
   parameter int AW         = FIR_AW,
   parameter int APPROX_LSB = FIR_APPROX_LSB
)(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [DW-1:0]           in_data,
   input  logic                    approx_en,
   input  logic                    coef_we,
   input  logic [$clog2(TAPS)-1:0] coef_addr,
   input  logic [CW-1:0]           coef_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [AW-1:0]           out_data,
   output logic                    busy
);

   localparam int KW = $clog2(TAPS);
   localparam int PW = DW + CW;

   state_t        state;
   logic [DW-1:0] x_q [TAPS];
   logic [CW-1:0] h_q [TAPS];
   logic [AW-1:0] acc_q;
   logic [KW-1:0] k_q;
   logic          mode_q;

   logic signed [DW-1:0] x_cur;
   logic signed [CW-1:0] h_cur;
   logic signed [PW-1:0] prod;
   logic        [AW-1:0] prod_ext;
   logic        [AW-1:0] sum;

   assign in_ready = (state == IDLE);
   assign busy     = (state != IDLE);

   // Full-precision signed product, then sign-extended to accumulator width
   assign x_cur    = x_q[k_q];
   assign h_cur    = h_q[k_q];
   assign prod     = PW'(x_cur) * PW'(h_cur);
   assign prod_ext = AW'(prod);

   eta_acc_adder #(
      .AW         (AW),
      .APPROX_LSB (APPROX_LSB)
   ) u_add (
      .a         (acc_q),
      .b         (prod_ext),
      .approx_en (mode_q),
      .sum       (sum)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         for (int i = 0; i < TAPS; i++) begin
            x_q[i] <= '0;
            h_q[i] <= '0;
         end
         acc_q     <= '0;
         k_q       <= '0;
         mode_q    <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
      end else begin
         case (state)
            IDLE: begin
               // A write in the accept cycle lands before tap 0 is read
               if (coef_we) h_q[coef_addr] <= coef_data;
               if (in_valid) begin
                  x_q[0] <= in_data;
                  for (int i = 1; i < TAPS; i++) x_q[i] <= x_q[i-1];
                  acc_q  <= '0;
                  k_q    <= '0;
                  mode_q <= approx_en;
                  state  <= MAC;
               end
            end
            MAC: begin
               acc_q <= sum;
               k_q   <= k_q + KW'(1);
               if (k_q == KW'(TAPS - 1)) begin
                  out_data  <= sum;
                  out_valid <= 1'b1;
                  state     <= OUT;
               end
            end
            OUT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fir_serial_mac.sv
// tb_fir_serial_mac
// Directed bench for fir_serial_mac: a vector table of coefficient writes and
// samples with hand-computed results, then hand-written sequences for
// backpressure, dropped coefficient writes and reset during MAC.
module tb_fir_serial_mac;

   localparam int TAPS = 8;
   localparam int DW   = 16;
   localparam int CW   = 16;
   localparam int AW   = 32;

   logic                    clk;
   logic                    rst_n;
   logic                    in_valid;
   logic                    in_ready;
   logic [DW-1:0]           in_data;
   logic                    approx_en;
   logic                    coef_we;
   logic [$clog2(TAPS)-1:0] coef_addr;
   logic [CW-1:0]           coef_data;
   logic                    out_valid;
   logic                    out_ready;
   logic [AW-1:0]           out_data;
   logic                    busy;

   fir_serial_mac dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .approx_en (approx_en),
      .coef_we   (coef_we),
      .coef_addr (coef_addr),
      .coef_data (coef_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .busy      (busy)
   );

   // ---------------- clock / cycle counter ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard ----------------
   logic [AW-1:0] exp_q[$];
   int checks = 0;
   int errors = 0;
   int acc_cyc = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got=%h want=%h", name, got, want);
      end
   endtask

   // ---------------- drivers (called at a falling edge) ----------------
   task automatic write_coef(input logic [2:0] a, input logic [15:0] d);
      coef_we   = 1'b1;
      coef_addr = a;
      coef_data = d;
      @(negedge clk);
      coef_we   = 1'b0;
   endtask

   // Offer a sample until accepted; returns at the falling edge of MAC cycle 1
   task automatic accept(input logic [15:0] d, input logic a);
      int n;
      n = 0;
      in_valid  = 1'b1;
      in_data   = d;
      approx_en = a;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("in_ready_wait", in_ready, 1'b1);
      acc_cyc = cyc;
      @(negedge clk);
      in_valid = 1'b0;
      check("busy_in_mac", busy, 1'b1);
      check("in_ready_in_mac", in_ready, 1'b0);
   endtask

   // Wait for out_valid; start = cycles already elapsed since the accept cycle
   task automatic wait_out(input string name, input int start);
      int n;
      logic [AW-1:0] want;
      n = start;
      while (!out_valid && n < 60) begin
         @(negedge clk);
         n++;
      end
      check({name, "_latency"}, n, TAPS + 1);
      if (exp_q.size() > 0) want = exp_q.pop_front();
      else want = 'x;
      check(name, out_data, want);
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic        wr;
      logic [2:0]  addr;
      logic [15:0] coef;
      logic [15:0] sample;
      logic        approx;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk_w(input logic [2:0] a, input logic [15:0] c);
      vec_t v;
      v.wr = 1'b1; v.addr = a; v.coef = c; v.sample = '0; v.approx = 1'b0; v.exp = '0;
      return v;
   endfunction

   function automatic vec_t mk_s(input logic [15:0] s, input logic ap, input logic [31:0] e);
      vec_t v;
      v.wr = 1'b0; v.addr = '0; v.coef = '0; v.sample = s; v.approx = ap; v.exp = e;
      return v;
   endfunction

   initial begin
      int prev_acc;
      bit prev_send;
      bit seen;

      // impulse response with h = 1..8
      for (int k = 0; k < TAPS; k++) vecs.push_back(mk_w(3'(k), 16'(k + 1)));
      vecs.push_back(mk_s(16'h0001, 1'b0, 32'h1));
      for (int k = 1; k < TAPS; k++) vecs.push_back(mk_s(16'h0000, 1'b0, 32'(k + 1)));
      // h0 = h1 = 1, rest 0
      vecs.push_back(mk_w(3'd0, 16'h0001));
      vecs.push_back(mk_w(3'd1, 16'h0001));
      for (int k = 2; k < TAPS; k++) vecs.push_back(mk_w(3'(k), 16'h0000));
      vecs.push_back(mk_s(16'h00FF, 1'b0, 32'h000000FF));
      vecs.push_back(mk_s(16'h0001, 1'b1, 32'h000000E0));  // carry lost at segment 0
      vecs.push_back(mk_s(16'h00FF, 1'b0, 32'h00000100));  // 0xFF + 0x01 exact
      vecs.push_back(mk_s(16'h0001, 1'b0, 32'h00000100));
      vecs.push_back(mk_s(16'h7FFF, 1'b1, 32'h00007FE0));  // 0x7FFF + 1, approximate
      // signed products
      vecs.push_back(mk_w(3'd0, 16'hFFFF));
      vecs.push_back(mk_w(3'd1, 16'h0000));
      vecs.push_back(mk_s(16'h7FFF, 1'b0, 32'hFFFF8001));
      vecs.push_back(mk_s(16'h0001, 1'b1, 32'hFFFFFFFF));
      vecs.push_back(mk_w(3'd0, 16'h8000));
      vecs.push_back(mk_s(16'h8000, 1'b0, 32'h40000000));
      vecs.push_back(mk_s(16'h8000, 1'b1, 32'h40000000));

      // ---------------- reset ----------------
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      approx_en = 1'b0;
      coef_we   = 1'b0;
      coef_addr = '0;
      coef_data = '0;
      out_ready = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("reset_in_ready", in_ready, 1'b1);
      check("reset_busy", busy, 1'b0);
      check("reset_out_valid", out_valid, 1'b0);
      check("reset_out_data", out_data, 32'h0);

      // ---------------- table ----------------
      prev_send = 1'b0;
      prev_acc  = 0;
      foreach (vecs[i]) begin
         if (vecs[i].wr) begin
            write_coef(vecs[i].addr, vecs[i].coef);
            prev_send = 1'b0;
         end else begin
            exp_q.push_back(vecs[i].exp);
            accept(vecs[i].sample, vecs[i].approx);
            if (prev_send) check($sformatf("interval_%0d", i), acc_cyc - prev_acc, TAPS + 2);
            prev_acc = acc_cyc;
            wait_out($sformatf("vec_%0d", i), 1);
            @(negedge clk);
            prev_send = 1'b1;
         end
      end

      // ---------------- backpressure ----------------
      // history is [8000,8000,0001,7FFF,...]; h0=1, h1=2, others 0
      write_coef(3'd0, 16'h0001);
      write_coef(3'd1, 16'h0002);
      out_ready = 1'b0;
      exp_q.push_back(32'hFFFF0003);  // 3 + 2*(-32768)
      accept(16'h0003, 1'b0);
      wait_out("bp_result", 1);
      in_valid = 1'b1;
      in_data  = 16'h5555;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check($sformatf("bp_hold_data_%0d", i), out_data, 32'hFFFF0003);
         check($sformatf("bp_in_ready_%0d", i), in_ready, 1'b0);
         check($sformatf("bp_out_valid_%0d", i), out_valid, 1'b1);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      check("bp_released_out_valid", out_valid, 1'b0);
      check("bp_released_in_ready", in_ready, 1'b1);
      exp_q.push_back(32'h0000000B);  // 5 + 2*3: held in_valid was not taken
      accept(16'h0005, 1'b0);
      wait_out("bp_next", 1);
      @(negedge clk);

      // ---------------- coefficient write during MAC ----------------
      exp_q.push_back(32'h0000001A);  // 0x10 + 2*5
      accept(16'h0010, 1'b0);
      coef_we   = 1'b1;
      coef_addr = 3'd3;
      coef_data = 16'h0007;
      @(negedge clk);
      coef_we = 1'b0;
      wait_out("mac_write_cur", 2);
      @(negedge clk);
      exp_q.push_back(32'h00000020);  // h3 still 0: 2*0x10
      accept(16'h0000, 1'b0);
      wait_out("mac_write_dropped", 1);
      @(negedge clk);
      write_coef(3'd3, 16'h0007);
      exp_q.push_back(32'h00000023);  // 7*5
      accept(16'h0000, 1'b0);
      wait_out("idle_write_applied", 1);
      @(negedge clk);

      // ---------------- reset during MAC ----------------
      accept(16'h0001, 1'b0);
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_out_valid", out_valid, 1'b0);
      check("midrst_busy", busy, 1'b0);
      check("midrst_in_ready", in_ready, 1'b1);
      check("midrst_out_data", out_data, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < TAPS + 4; i++) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      check("midrst_no_out_valid", seen, 1'b0);
      exp_q.push_back(32'h0);  // coefficients cleared by reset
      accept(16'h0001, 1'b0);
      wait_out("post_reset_impulse", 1);
      @(negedge clk);
      // write in the accept cycle applies to that sample: 9*2 + 0*1
      coef_we   = 1'b1;
      coef_addr = 3'd0;
      coef_data = 16'h0009;
      exp_q.push_back(32'h00000012);
      accept(16'h0002, 1'b0);
      coef_we = 1'b0;
      wait_out("accept_cycle_write", 1);
      @(negedge clk);

      check("scoreboard_empty", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fir_serial_mac.md
# fir_serial_mac

Time-multiplexed FIR filter engine: accepts one signed sample per handshake, shifts it into a TAPS-deep delay line, and computes y = Σ h[k]·x[n−k] with one multiplier and one accumulator over TAPS cycles. The accumulator adder runs exact or error-tolerant (segmented, carry-truncated low bits) per sample. It is the MAC stage that produces the operand stream for the design's approximate 32-bit adders, and it hands finished outputs downstream over a valid/ready port.

## Interface
- TAPS, 8: number of taps, ≥2, power of two.
- DW, 16: signed sample width.
- CW, 16: signed coefficient width.
- AW, 32: accumulator/output width, ≥ DW+CW.
- APPROX_LSB, 20: approximate low-bit span, multiple of 4, 0 ≤ APPROX_LSB < AW.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  sample offered.
- in_ready  out  1  engine can accept a sample.
- in_data  in  DW  signed sample.
- approx_en  in  1  approximate mode for this sample, sampled at accept.
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  log2(TAPS)  coefficient index k.
- coef_data  in  CW  signed coefficient h[k].
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_data  out  AW  signed result, two's complement.
- busy  out  1  high in MAC or OUT.

## Operation
- FSM: IDLE → MAC → OUT → IDLE.
- IDLE: in_ready=1. On in_valid&in_ready: x[k]←x[k−1] for k≥1, x[0]←in_data; acc←0; k←0; mode←approx_en; go MAC.
- MAC: each cycle acc←add(acc, sext(x[k]·h[k])); k←k+1; after k=TAPS−1 go OUT, out_data←final acc.
- OUT: out_valid=1, out_data stable; on out_ready go IDLE. No accept in OUT (in_ready=0).
- Coefficient writes honoured only in IDLE, including the accept cycle (new h applies to that sample). In MAC/OUT coef_we is ignored (dropped, not queued).
- add(): mode=0 or APPROX_LSB=0 → exact AW-bit sum mod 2^AW.
- mode=1: bits [APPROX_LSB−1:0] split into 4-bit segments. Segment 0 carry-in=0. Within each segment, internal carries are computed as if carry-in were 0 (generate/propagate lookahead). The segment's true carry-in only XORs into its lowest sum bit. Carry into segment j = lookahead carry-out of segment j−1 computed with carry-in 0.
- Bits [AW−1:APPROX_LSB]: exact carry-lookahead with carry-in = that truncated carry-out of the top approximate segment.
- Overflow wraps mod 2^AW; no saturation, no flag.
- Reset: state IDLE, delay line 0, coefficients 0, acc 0, k 0, out_valid 0, out_data 0, busy 0, in_ready 1 (combinational from IDLE).

## Timing
- Accept at edge t → MAC on cycles t+1..t+TAPS → out_valid high from edge t+TAPS+1.
- Minimum sample interval TAPS+2 cycles with out_ready held high.
- out_valid/out_data registered. in_ready/busy decoded from state, no input-to-output combinational path.
- out_ready low: hold OUT indefinitely, out_data unchanged, in_ready 0.
- Reset asserted mid-MAC or mid-OUT: immediate return to reset values; partial result discarded, no out_valid.

## Structure
- Package fir_pkg holds the FSM state enum (IDLE, MAC, OUT) and the default TAPS/DW/CW/AW/APPROX_LSB constants.
- Sub-module eta_acc_adder: combinational AW-bit adder with inputs a, b, approx_en and parameter APPROX_LSB, implementing add() exactly as above. Instantiated once.
- Top: FSM, tap counter, delay line, coefficient register file, multiplier, acc register.

## Test plan
- Impulse, exact: h=1..8, samples 1 then seven 0s → outputs 1,2,3,4,5,6,7,8, each out_valid exactly TAPS+1 cycles after accept.
- Approx carry loss: h[0]=h[1]=1, rest 0. Samples 0xFF then 0x01, approx_en=1 → second out_data=0x000000E0. Same with approx_en=0 → 0x00000100.
- Signed exact: h[0]=−1, sample 0x7FFF → out_data=0xFFFF8001. With h[0]=0x8000, sample 0x8000 → 0x40000000.
- Backpressure: out_ready low 20 cycles in OUT → out_data constant, in_ready 0, in_valid ignored. Release → one transfer, in_ready 1 next cycle.
- Coef write during MAC to h[3] → dropped; the following sample uses the old h[3]. Write in IDLE → applied.
- rst_n pulsed low at MAC cycle 3 → out_valid never asserts. Next sample with impulse → output 0 because coefficients were cleared.
